// File: rtl/board_reset_ctrl_pkg.sv
// rtl/board_reset_ctrl_pkg.sv - shared FSM encoding and counter sizing for board_reset_ctrl
package board_reset_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PULSE        = 2'd1,
    WAIT_RELEASE = 2'd2
  } rst_state_t;

  localparam int PRESS_CNT_W = 8;

  // A down/up counter that must hold the value n needs clog2(n)+1 bits.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/board_reset_ctrl_debounce.sv
// rtl/board_reset_ctrl_debounce.sv - two-flop synchroniser plus stability counter for an active-low button
module btn_debounce
  import board_reset_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic stable
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  // Any return to the accepted level restarts the count, so only an
  // uninterrupted run of DEBOUNCE_CYCLES differing samples is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b1;
      cnt    <= '0;
    end else if (sync2 == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= sync2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/board_reset_ctrl.sv
// rtl/board_reset_ctrl.sv - debounced board reset button to fixed-width SoC reset request pulse
module board_reset_ctrl
  import board_reset_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PULSE_CYCLES    = 16,
  parameter bit POR_EN          = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   btn_n,
  output logic                   rst_req,
  output logic                   btn_pressed,
  output logic                   busy,
  output logic [PRESS_CNT_W-1:0] press_count
);

  localparam int            PW         = cnt_width(PULSE_CYCLES);
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);

  rst_state_t    state;
  rst_state_t    state_d;
  logic [PW-1:0] pcnt;
  logic [PW-1:0] pcnt_d;
  logic          stable;
  logic          stable_q;
  logic          press_evt;
  logic          por_pending;
  logic          cnt_inc;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_n),
    .stable(stable)
  );

  assign btn_pressed = ~stable;
  assign press_evt   = stable_q & ~stable;

  always_comb begin
    state_d = state;
    pcnt_d  = pcnt;
    cnt_inc = 1'b0;
    case (state)
      IDLE: begin
        if (POR_EN && por_pending) begin
          state_d = PULSE;
          pcnt_d  = PULSE_LAST;
        end else if (press_evt) begin
          state_d = PULSE;
          pcnt_d  = PULSE_LAST;
          cnt_inc = 1'b1;
        end
      end
      PULSE: begin
        if (pcnt == '0) begin
          state_d = stable ? IDLE : WAIT_RELEASE;
        end else begin
          pcnt_d = pcnt - PW'(1);
        end
      end
      WAIT_RELEASE: begin
        if (stable) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // rst_req and busy are decoded from the next state so both come straight off flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pcnt        <= '0;
      rst_req     <= 1'b0;
      busy        <= 1'b0;
      press_count <= '0;
      stable_q    <= 1'b1;
      por_pending <= 1'b1;
    end else begin
      state       <= state_d;
      pcnt        <= pcnt_d;
      rst_req     <= (state_d == PULSE);
      busy        <= (state_d != IDLE);
      stable_q    <= stable;
      por_pending <= 1'b0;
      if (cnt_inc) begin
        press_count <= press_count + PRESS_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_board_reset_ctrl.sv
// tb/tb_board_reset_ctrl.sv - self-checking bench for board_reset_ctrl with a pulse scoreboard
module tb_board_reset_ctrl;

  localparam int DB = 4;
  localparam int PC = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_n;
  logic       btn_por_n;
  logic       rst_req, btn_pressed, busy;
  logic [7:0] press_count;
  logic       por_rst_req, por_btn_pressed, por_busy;
  logic [7:0] por_press_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    int rise;
    int len;
    int count;
  } exp_t;
  exp_t sb[$];

  board_reset_ctrl #(.DEBOUNCE_CYCLES(DB), .PULSE_CYCLES(PC), .POR_EN(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .rst_req(rst_req),
    .btn_pressed(btn_pressed), .busy(busy), .press_count(press_count)
  );

  board_reset_ctrl #(.DEBOUNCE_CYCLES(DB), .PULSE_CYCLES(PC), .POR_EN(1'b1)) dut_por (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_por_n), .rst_req(por_rst_req),
    .btn_pressed(por_btn_pressed), .busy(por_busy), .press_count(por_press_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_pulse(input int rise, input int count);
    exp_t e;
    e.rise  = rise;
    e.len   = PC;
    e.count = count & 255;
    sb.push_back(e);
  endtask

  // Pulse monitor for the POR_EN=0 instance: measures each rst_req pulse and scores it.
  initial begin
    int   len;
    int   rise;
    logic prev;
    exp_t e;
    len  = 0;
    rise = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
        len  = 0;
      end else begin
        if (rst_req && !prev) begin
          rise = cyc;
          len  = 1;
        end else if (rst_req) begin
          len++;
        end else if (prev) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL sb_unexpected_pulse: got pulse rise=%0d len=%0d, want none", rise, len);
          end else begin
            e = sb.pop_front();
            if (rise !== e.rise || len !== e.len || press_count !== 8'(e.count)) begin
              n_bad++;
              $display("FAIL sb_pulse: got rise=%0d len=%0d count=%0d, want rise=%0d len=%0d count=%0d",
                       rise, len, press_count, e.rise, e.len, e.count);
            end
          end
        end
        prev = rst_req;
      end
    end
  end

  task automatic test_reset();
    rst_n     = 1'b0;
    btn_n     = 1'b1;
    btn_por_n = 1'b1;
    tick(3);
    n_cmp++;
    if ({rst_req, busy, btn_pressed, press_count} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_dut: got req=%b busy=%b pressed=%b count=%0d, want all 0",
               rst_req, busy, btn_pressed, press_count);
    end
    n_cmp++;
    if ({por_rst_req, por_busy, por_btn_pressed, por_press_count} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_por: got req=%b busy=%b pressed=%b count=%0d, want all 0",
               por_rst_req, por_busy, por_btn_pressed, por_press_count);
    end
  endtask

  task automatic test_por();
    logic exp_hi;
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      exp_hi = (i <= PC);
      n_cmp++;
      if ({por_rst_req, por_busy, por_press_count, rst_req} !== {exp_hi, exp_hi, 8'd0, 1'b0}) begin
        n_bad++;
        $display("FAIL por_cycle%0d: got req=%b busy=%b count=%0d dut_req=%b, want req=%b busy=%b count=0 dut_req=0",
                 i, por_rst_req, por_busy, por_press_count, rst_req, exp_hi, exp_hi);
      end
    end
  endtask

  task automatic test_press_held();
    int k;
    int r;
    k     = cyc;
    btn_n = 1'b0;
    expect_pulse(k + 2 + DB + 1, 1);
    for (int m = 1; m <= 100; m++) begin
      tick(1);
      if (m == 2 + DB - 1) begin
        n_cmp++;
        if (btn_pressed !== 1'b0) begin
          n_bad++;
          $display("FAIL held_pressed_early: got %b want 0", btn_pressed);
        end
      end
      if (m == 2 + DB) begin
        n_cmp++;
        if (btn_pressed !== 1'b1) begin
          n_bad++;
          $display("FAIL held_pressed_rise: got %b want 1", btn_pressed);
        end
      end
      if (m == 12) begin
        n_cmp++;
        if ({busy, rst_req, press_count} !== {1'b1, 1'b0, 8'd1}) begin
          n_bad++;
          $display("FAIL held_wait_release: got busy=%b req=%b count=%0d, want busy=1 req=0 count=1",
                   busy, rst_req, press_count);
        end
      end
    end
    r     = cyc;
    btn_n = 1'b1;
    tick(2 + DB);
    n_cmp++;
    if ({busy, btn_pressed} !== 2'b10) begin
      n_bad++;
      $display("FAIL held_release_pending: got busy=%b pressed=%b at cyc %0d, want busy=1 pressed=0", busy, btn_pressed, cyc - r);
    end
    tick(1);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL held_release_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_bounce();
    logic [7:0] base;
    logic       seen;
    base = press_count;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      btn_n = 1'b0;
      tick(1); seen |= btn_pressed;
      tick(1); seen |= btn_pressed;
      btn_n = 1'b1;
      tick(1); seen |= btn_pressed;
      tick(1); seen |= btn_pressed;
    end
    for (int i = 0; i < 20; i++) begin
      tick(1);
      seen |= btn_pressed;
    end
    n_cmp++;
    if ({seen, busy, press_count} !== {1'b0, 1'b0, base}) begin
      n_bad++;
      $display("FAIL bounce: got seen_pressed=%b busy=%b count=%0d, want 0 0 %0d", seen, busy, press_count, base);
    end
  endtask

  task automatic test_short_press();
    logic [7:0] exp_cnt;
    int         k;
    exp_cnt = press_count + 8'd1;
    k       = cyc;
    btn_n   = 1'b0;
    expect_pulse(k + 2 + DB + 1, int'(exp_cnt));
    tick(6);
    btn_n = 1'b1;
    tick(7);
    n_cmp++;
    if ({busy, btn_pressed, press_count} !== {1'b0, 1'b0, exp_cnt}) begin
      n_bad++;
      $display("FAIL short_press: got busy=%b pressed=%b count=%0d, want 0 0 %0d",
               busy, btn_pressed, press_count, exp_cnt);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int guard;
    btn_n = 1'b0;
    guard = 0;
    while (rst_req !== 1'b1 && guard < 20) begin
      tick(1);
      guard++;
    end
    n_cmp++;
    if (rst_req !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_wait_pulse: got rst_req=%b after %0d cycles, want 1", rst_req, guard);
    end
    tick(1);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rst_req, busy, press_count} !== 10'd0) begin
      n_bad++;
      $display("FAIL midrst_dut: got req=%b busy=%b count=%0d, want all 0", rst_req, busy, press_count);
    end
    btn_n = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    n_cmp++;
    if (por_rst_req !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_por_high: got %b want 1", por_rst_req);
    end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({por_rst_req, por_busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL midrst_por: got req=%b busy=%b, want 0 0", por_rst_req, por_busy);
    end
    tick(1);
    rst_n = 1'b1;
    tick(6);
  endtask

  task automatic test_wrap();
    int k;
    for (int i = 0; i < 256; i++) begin
      k     = cyc;
      btn_n = 1'b0;
      expect_pulse(k + 2 + DB + 1, i + 1);
      tick(10);
      if (i == 254) begin
        n_cmp++;
        if (press_count !== 8'd255) begin
          n_bad++;
          $display("FAIL wrap_255: got %0d want 255", press_count);
        end
      end
      btn_n = 1'b1;
      tick(10);
    end
    n_cmp++;
    if (press_count !== 8'd0) begin
      n_bad++;
      $display("FAIL wrap_zero: got %0d want 0", press_count);
    end
  endtask

  task automatic test_drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      tick(1);
      guard++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d pulses outstanding, want 0", sb.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_por();
    test_press_held();
    test_bounce();
    test_short_press();
    test_drain();
    test_reset_mid_pulse();
    test_wrap();
    test_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
